// File: rtl/usr_frame_rx.sv
// -----------------------------------------------------------------------------
// usr_frame_rx
//
// Serial frame receiver fed by the universal shift register's serial output.
// A frame is: start bit (0), n data bits LSB first, an optional even-parity
// bit, and a stop bit (1). Bits are taken only on clock edges where sin_en=1,
// so the receiver follows the shift register at whatever rate it shifts.
// Completed good frames are offered on a valid/ready holding register.
//
// Optional feature macro: USR_FRAME_RX_PARITY_EN
//   defined   -> frame carries an even-parity bit after the data bits; the
//                XOR of data and parity bit must be 0, otherwise frm_err.
//   undefined -> frame is start + n data + stop; only the stop bit is checked.
//
// Parameters:
//   n         data word width (>= 2)
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-low reset
//   sin       in   1  serial data from the shift register
//   sin_en    in   1  sample strobe; sin is taken only when 1
//   dout      out  n  received word (valid while dout_vld=1)
//   dout_vld  out  1  dout holds an undelivered word
//   dout_rdy  in   1  consumer accepts the word
//   busy      out  1  a frame is in progress
//   frm_err   out  1  one-cycle pulse: bad stop bit or parity mismatch
//   ovf       out  1  one-cycle pulse: good frame dropped, holding reg full
// -----------------------------------------------------------------------------
module usr_frame_rx #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_en,
    output logic [n-1:0] dout,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic         busy,
    output logic         frm_err,
    output logic         ovf
);

    // Bit counter only has to address positions 0..n-1 of the shift buffer.
    localparam int CW = (n > 1) ? $clog2(n) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_DATA = 2'b01;
`ifdef USR_FRAME_RX_PARITY_EN
    localparam logic [1:0] ST_PAR  = 2'b10;
`endif
    localparam logic [1:0] ST_STOP = 2'b11;

`ifdef USR_FRAME_RX_PARITY_EN
    // Even parity passes when data bits plus parity bit contain an even
    // number of ones.
    function automatic logic even_parity_ok(input logic [n-1:0] data,
                                            input logic         pbit);
        return ~(^{data, pbit});
    endfunction
`endif

    // Receiver state
    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [n-1:0]  shbuf_r;
    logic [n-1:0]  shbuf_s;
`ifdef USR_FRAME_RX_PARITY_EN
    logic          par_r;
    logic          par_s;
`endif

    // Stop-bit edge results
    logic          stop_seen_s;
    logic          frame_good_s;

    // Holding register and flag next values
    logic          hold_free_s;
    logic          load_s;
    logic [n-1:0]  dout_s;
    logic          dout_vld_s;
    logic          frm_err_s;
    logic          ovf_s;
    logic          busy_s;

    logic [n-1:0]  dout_r;
    logic          dout_vld_r;
    logic          busy_r;
    logic          frm_err_r;
    logic          ovf_r;

    // Next-state logic: the FSM, counter and buffer move only on sampled bits.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shbuf_s      = shbuf_r;
`ifdef USR_FRAME_RX_PARITY_EN
        par_s        = par_r;
`endif
        stop_seen_s  = 1'b0;
        frame_good_s = 1'b0;
        if (sin_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (sin == 1'b0) begin
                        cnt_s   = {CW{1'b0}};
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shbuf_s[cnt_r] = sin;
                    if (cnt_r == CW'(n - 1)) begin
`ifdef USR_FRAME_RX_PARITY_EN
                        state_s = ST_PAR;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
`ifdef USR_FRAME_RX_PARITY_EN
                ST_PAR: begin
                    par_s   = sin;
                    state_s = ST_STOP;
                end
`endif
                ST_STOP: begin
                    // A 0 here is a framing error, never a new start bit.
                    stop_seen_s = 1'b1;
`ifdef USR_FRAME_RX_PARITY_EN
                    frame_good_s = sin & even_parity_ok(shbuf_r, par_r);
`else
                    frame_good_s = sin;
`endif
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Delivery and handshake: the holding register is free when empty or
    // being drained on this same edge.
    always_comb begin
        hold_free_s = (~dout_vld_r) | dout_rdy;
        load_s      = stop_seen_s & frame_good_s & hold_free_s;
        ovf_s       = stop_seen_s & frame_good_s & ~hold_free_s;
        frm_err_s   = stop_seen_s & ~frame_good_s;
        busy_s      = (state_s != ST_IDLE);
        if (load_s) begin
            dout_s     = shbuf_r;
            dout_vld_s = 1'b1;
        end else if (dout_rdy) begin
            dout_s     = dout_r;
            dout_vld_s = 1'b0;
        end else begin
            dout_s     = dout_r;
            dout_vld_s = dout_vld_r;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            shbuf_r <= {n{1'b0}};
`ifdef USR_FRAME_RX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shbuf_r <= shbuf_s;
`ifdef USR_FRAME_RX_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

    // Output registers: holding register, busy and the one-cycle flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r     <= {n{1'b0}};
            dout_vld_r <= 1'b0;
            busy_r     <= 1'b0;
            frm_err_r  <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            dout_r     <= dout_s;
            dout_vld_r <= dout_vld_s;
            busy_r     <= busy_s;
            frm_err_r  <= frm_err_s;
            ovf_r      <= ovf_s;
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign busy     = busy_r;
    assign frm_err  = frm_err_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_usr_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_usr_frame_rx
//
// Directed scenarios followed by randomized streams. A frame-level reference
// model collects sampled bits into a list, judges each complete frame from its
// bit values, and applies the holding-register delivery rules. Every cycle all
// outputs are compared with the model; key scenario points are also compared
// with literal expected values.
// -----------------------------------------------------------------------------
module tb_usr_frame_rx;

    localparam int N = 4;
`ifdef USR_FRAME_RX_PARITY_EN
    localparam int FL = N + 2;   // bits after the start bit: data, parity, stop
`else
    localparam int FL = N + 1;   // bits after the start bit: data, stop
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b1;
    logic         sin_en = 1'b0;
    logic         dout_rdy = 1'b0;
    logic [N-1:0] dout;
    logic         dout_vld;
    logic         busy;
    logic         frm_err;
    logic         ovf;

    usr_frame_rx #(.n(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .sin_en   (sin_en),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .busy     (busy),
        .frm_err  (frm_err),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit           m_inframe;
    bit           m_bits[$];
    logic [N-1:0] m_dout;
    bit           m_vld;
    bit           m_ferr;
    bit           m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inframe = 1'b0;
        m_bits.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs currently driven.
    task automatic model_edge();
        bit           good = 1'b0;
        bit           bad = 1'b0;
        bit           par_ok = 1'b1;
        int           ones = 0;
        logic [N-1:0] word = '0;
        if (sin_en) begin
            if (!m_inframe) begin
                if (sin == 1'b0) begin
                    m_inframe = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(sin);
                if (m_bits.size() == FL) begin
                    for (int i = 0; i < N; i++) begin
                        word[i] = m_bits[i];
                        ones += int'(m_bits[i]);
                    end
`ifdef USR_FRAME_RX_PARITY_EN
                    ones += int'(m_bits[N]);
                    par_ok = (ones % 2 == 0);
`endif
                    if (m_bits[FL-1] == 1'b1 && par_ok) good = 1'b1;
                    else bad = 1'b1;
                    m_inframe = 1'b0;
                end
            end
        end
        m_ferr = bad;
        m_ovf  = 1'b0;
        if (good && (!m_vld || dout_rdy)) begin
            m_dout = word;
            m_vld  = 1'b1;
        end else begin
            if (good) m_ovf = 1'b1;
            if (dout_rdy) m_vld = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("dout",     32'(dout),     32'(m_dout));
        chk("dout_vld", 32'(dout_vld), 32'(m_vld));
        chk("busy",     32'(busy),     32'(m_inframe));
        chk("frm_err",  32'(frm_err),  32'(m_ferr));
        chk("ovf",      32'(ovf),      32'(m_ovf));
    endtask

    // Drive inputs (at the falling edge), take one rising edge, compare at the
    // next falling edge.
    task automatic step(input bit s, input bit en, input bit r);
        sin      = s;
        sin_en   = en;
        dout_rdy = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send_frame(input logic [N-1:0] d, input bit stopb, input bit parflip, input bit r);
        step(1'b0, 1'b1, r);
        for (int i = 0; i < N; i++) step(d[i], 1'b1, r);
`ifdef USR_FRAME_RX_PARITY_EN
        step((^d) ^ parflip, 1'b1, r);
`endif
        step(stopb, 1'b1, r);
    endtask

    initial begin
        bit gs[6];
        model_reset();
        // Power-on reset
        #2 rst = 1'b0;
        #1;
        chk("rst_dout",     32'(dout),     32'h0);
        chk("rst_dout_vld", 32'(dout_vld), 32'h0);
        chk("rst_busy",     32'(busy),     32'h0);
        chk("rst_frm_err",  32'(frm_err),  32'h0);
        chk("rst_ovf",      32'(ovf),      32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Basic receive
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        send_frame(4'b1001, 1'b1, 1'b0, 1'b1);
        chk("basic_dout", 32'(dout),     32'h9);
        chk("basic_vld",  32'(dout_vld), 32'h1);
        step(1'b1, 1'b1, 1'b1);
        chk("basic_vld_drop", 32'(dout_vld), 32'h0);

        // Gated sampling: each bit held two cycles, strobe on the first
        gs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step(gs[i], 1'b1, 1'b1);
            step(gs[i], 1'b0, 1'b1);
        end
        chk("gated_dout", 32'(dout), 32'h9);
        step(1'b1, 1'b1, 1'b1);

        // Framing error then a good frame
        send_frame(4'b1011, 1'b0, 1'b0, 1'b1);
        chk("ferr_pulse", 32'(frm_err),  32'h1);
        chk("ferr_vld",   32'(dout_vld), 32'h0);
        chk("ferr_busy",  32'(busy),     32'h0);
        send_frame(4'b1011, 1'b1, 1'b0, 1'b1);
        chk("after_ferr_dout", 32'(dout),     32'hB);
        chk("after_ferr_vld",  32'(dout_vld), 32'h1);
        step(1'b1, 1'b1, 1'b1);

        // Overrun
        send_frame(4'b1001, 1'b1, 1'b0, 1'b0);
        send_frame(4'b1101, 1'b1, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(ovf),      32'h1);
        chk("ovf_dout",  32'(dout),     32'h9);
        chk("ovf_vld",   32'(dout_vld), 32'h1);
        step(1'b1, 1'b1, 1'b1);
        chk("drain_vld", 32'(dout_vld), 32'h0);
        step(1'b1, 1'b1, 1'b1);
        chk("drain_only_one", 32'(dout_vld), 32'h0);

`ifdef USR_FRAME_RX_PARITY_EN
        // Parity good and bad
        send_frame(4'b1001, 1'b1, 1'b0, 1'b1);
        chk("par_dout", 32'(dout),     32'h9);
        chk("par_vld",  32'(dout_vld), 32'h1);
        step(1'b1, 1'b1, 1'b1);
        send_frame(4'b1001, 1'b1, 1'b1, 1'b1);
        chk("par_err",     32'(frm_err),  32'h1);
        chk("par_err_vld", 32'(dout_vld), 32'h0);
`endif

        // Reset mid-frame with a held word
        send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_dout",    32'(dout),     32'h0);
        chk("mid_rst_vld",     32'(dout_vld), 32'h0);
        chk("mid_rst_busy",    32'(busy),     32'h0);
        chk("mid_rst_frm_err", 32'(frm_err),  32'h0);
        chk("mid_rst_ovf",     32'(ovf),      32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        send_frame(4'b1001, 1'b1, 1'b0, 1'b1);
        chk("post_rst_dout", 32'(dout),     32'h9);
        chk("post_rst_vld",  32'(dout_vld), 32'h1);

        // Random well-formed and malformed frames, back to back
        for (int k = 0; k < 60; k++) begin
            send_frame(N'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 2) != 0));
        end

        // Random raw bit stream with random strobe and ready
        for (int k = 0; k < 800; k++) begin
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
